load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
Multicycle load/store sequencer between the processor control FSM/datapath and the 64-bit data memory. It accepts one RV64I load or store request (lb/lh/lw/ld/lbu/lhu/lwu, sb/sh/sw/sd) and drives doubleword-aligned memory accesses. Loads get byte-lane extraction with sign/zero extension. Sub-doubleword stores use read-modify-write merging. Misaligned or illegal accesses are flagged without touching memory.

Parameters:
MEM_LATENCY, 1, cycles from mem_raddress stable to mem_dataout valid (1..7).
ADDR_W, 64, byte address width.

Ports:
CLK  in  1  clock, rising edge
RST  in  1  asynchronous reset, active-low
req_valid  in  1  request strobe
req_ready  out  1  unit idle; request accepted when req_valid && req_ready
req_write  in  1  1 = store, 0 = load
req_funct3  in  3  RISC-V funct3 (size/sign)
req_addr  in  ADDR_W  byte address
req_wdata  in  64  store data (low bytes used)
resp_valid  out  1  one-cycle completion pulse
resp_rdata  out  64  extended load result
resp_misaligned  out  1  fault flag, valid with resp_valid
mem_raddress  out  ADDR_W  memory read address (aligned)
mem_waddress  out  ADDR_W  memory write address (aligned)
mem_datain  out  64  memory write data
mem_wr  out  1  memory write enable
mem_dataout  in  64  memory read data

Behaviour:
- Reset (RST=0, async): state IDLE. resp_valid=0, resp_rdata=0, resp_misaligned=0, mem_raddress=0, mem_waddress=0, mem_datain=0, mem_wr=0, latency counter=0. req_ready=1 (combinational, state==IDLE).
- On acceptance the unit registers write, funct3, addr and wdata. Inputs are ignored until it returns to IDLE.
- aligned = {addr[ADDR_W-1:3],3'b000}; off = addr[2:0].
- Fault rules:
  - h/hu: addr[0]!=0 is misaligned.
  - w/wu: addr[1:0]!=0 is misaligned.
  - d: off!=0 is misaligned.
  - Load funct3 011 (ld) is legal; load funct3 111 is illegal.
  - Store funct3 >= 100 is illegal.
  - Illegal counts as a fault.
- States: IDLE, RD_WAIT, WRITE, RESP.
- IDLE, request accepted:
  - fault → RESP.
  - load, or store with funct3 != 011 → RD_WAIT; counter = MEM_LATENCY; mem_raddress = aligned.
  - sd → WRITE.
- RD_WAIT: mem_raddress held. Counter decrements each cycle. In the cycle where counter==1, mem_dataout is captured into rd_buf at the edge. Next state is RESP for loads, WRITE for stores.
- WRITE (exactly one cycle): mem_wr=1, mem_waddress=aligned.
  - sd: mem_datain = wdata.
  - sb/sh/sw: mem_datain = rd_buf with bytes off..off+size-1 replaced by low bytes of wdata.
  - Next state RESP.
- RESP (one cycle):
  - resp_valid=1.
  - Loads: resp_rdata = bytes of rd_buf at off, sign-extended (funct3[2]=0) or zero-extended (funct3[2]=1).
  - Faults: resp_misaligned=1 and resp_rdata unchanged.
  - Stores: resp_rdata unchanged.
  - Next state IDLE.
- resp_rdata and resp_misaligned hold until the next RESP. resp_misaligned is cleared on non-fault responses. There is no response backpressure.
- Latency (acceptance cycle = 0), resp_valid cycle:
  - fault: 1.
  - sd: 2 (mem_wr in cycle 1).
  - load: MEM_LATENCY+1.
  - sb/sh/sw: MEM_LATENCY+2 (mem_wr in cycle MEM_LATENCY+1).
- A faulted request never asserts mem_wr.
- Reset mid-operation: immediate return to IDLE, mem_wr drops asynchronously, and no partial or late write occurs.
- req_valid while busy: ignored, not queued.

Test Plan:
1. Memory at 0x100 = 0x8877665544332211 (MEM_LATENCY=1).
   - lb 0x103 → resp_valid in cycle 2, rdata 0x0000000000000044.
   - lb 0x107 → 0xFFFFFFFFFFFFFF88.
   - lbu 0x107 → 0x0000000000000088.
2. Same word:
   - lhu 0x106 → 0x0000000000008877.
   - lw 0x104 → 0xFFFFFFFF88776655.
   - lwu 0x104 → 0x0000000088776655.
   - ld 0x100 → 0x8877665544332211.
3. sb 0x102, wdata 0x00000000000000AB → mem_raddress 0x100 in cycle 1; mem_wr=1 only in cycle 2 with mem_waddress 0x100 and mem_datain 0x8877665544AB2211; resp_valid in cycle 3, resp_misaligned=0.
4. sd 0x108, wdata 0x0123456789ABCDEF → mem_wr=1 in cycle 1, mem_datain 0x0123456789ABCDEF, resp_valid in cycle 2. sw 0x102 → resp_valid with resp_misaligned=1 in cycle 1, mem_wr never asserted. Load funct3 111 → also faults.
5. MEM_LATENCY=3: lh 0x100 → resp_valid in cycle 4, rdata 0x0000000000002211. A req_valid pulse during RD_WAIT → ignored, req_ready=0.
6. sh 0x104 with RST driven low in cycle 1 (RD_WAIT) → all outputs 0 immediately, mem_wr never high, req_ready=1. A new lb 0x100 after release → rdata 0x11.

Source files
------------

// File: rtl/load_store_unit.sv
// RV64I load/store sequencer: doubleword-aligned memory accesses, lane extract/extend, RMW for sub-word stores.
// Latency: fault 1, sd 2, load MEM_LATENCY+1, sb/sh/sw MEM_LATENCY+2; busy requests are dropped, no response backpressure.
module load_store_unit #(
  parameter int MEM_LATENCY = 1,
  parameter int ADDR_W      = 64
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [63:0]       req_wdata,
  output logic              resp_valid,
  output logic [63:0]       resp_rdata,
  output logic              resp_misaligned,
  output logic [ADDR_W-1:0] mem_raddress,
  output logic [ADDR_W-1:0] mem_waddress,
  output logic [63:0]       mem_datain,
  output logic              mem_wr,
  input  logic [63:0]       mem_dataout
);

  typedef enum logic [1:0] {IDLE, RD_WAIT, WRITE, RESP} state_t;

  state_t            state, state_nx;
  logic              wr_q;
  logic [2:0]        f3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [63:0]       wdata_q;
  logic [2:0]        cnt;
  logic              accept;
  logic              fault_in;
  logic [ADDR_W-1:0] aligned_in;
  logic [ADDR_W-1:0] aligned_q;

  function automatic logic is_fault(input logic wr, input logic [2:0] f3, input logic [2:0] off);
    logic bad;
    case (f3[1:0])
      2'b01:   bad = off[0];
      2'b10:   bad = |off[1:0];
      2'b11:   bad = |off;
      default: bad = 1'b0;
    endcase
    if (wr && f3[2]) bad = 1'b1;
    if (!wr && f3 == 3'b111) bad = 1'b1;
    return bad;
  endfunction

  function automatic logic [63:0] extract(input logic [63:0] dw, input logic [2:0] off, input logic [2:0] f3);
    logic [63:0] s;
    logic [63:0] r;
    s = dw >> {off, 3'b000};
    case (f3[1:0])
      2'b00:   r = f3[2] ? {56'd0, s[7:0]}  : {{56{s[7]}}, s[7:0]};
      2'b01:   r = f3[2] ? {48'd0, s[15:0]} : {{48{s[15]}}, s[15:0]};
      2'b10:   r = f3[2] ? {32'd0, s[31:0]} : {{32{s[31]}}, s[31:0]};
      default: r = s;
    endcase
    return r;
  endfunction

  function automatic logic [63:0] merge(input logic [63:0] dw, input logic [63:0] wd,
                                        input logic [2:0] off, input logic [2:0] f3);
    logic [63:0] m;
    case (f3[1:0])
      2'b00:   m = 64'h0000_0000_0000_00FF;
      2'b01:   m = 64'h0000_0000_0000_FFFF;
      2'b10:   m = 64'h0000_0000_FFFF_FFFF;
      default: m = 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
    m = m << {off, 3'b000};
    return (dw & ~m) | ((wd << {off, 3'b000}) & m);
  endfunction

  assign req_ready  = (state == IDLE);
  assign accept     = req_valid && req_ready;
  assign fault_in   = is_fault(req_write, req_funct3, req_addr[2:0]);
  assign aligned_in = {req_addr[ADDR_W-1:3], 3'b000};
  assign aligned_q  = {addr_q[ADDR_W-1:3], 3'b000};

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (fault_in)                                 state_nx = RESP;
          else if (req_write && req_funct3 == 3'b011)   state_nx = WRITE;
          else                                          state_nx = RD_WAIT;
        end
      end
      RD_WAIT: if (cnt == 3'd1) state_nx = wr_q ? WRITE : RESP;
      WRITE:   state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Outputs are registered on the edge that enters the state they belong to,
  // so the read word is consumed straight off mem_dataout at the capture edge.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      resp_valid      <= 1'b0;
      resp_rdata      <= '0;
      resp_misaligned <= 1'b0;
      mem_raddress    <= '0;
      mem_waddress    <= '0;
      mem_datain      <= '0;
      mem_wr          <= 1'b0;
      cnt             <= '0;
      wr_q            <= 1'b0;
      f3_q            <= '0;
      addr_q          <= '0;
      wdata_q         <= '0;
    end else begin
      resp_valid <= (state_nx == RESP);
      mem_wr     <= (state_nx == WRITE);
      case (state)
        IDLE: begin
          if (accept) begin
            wr_q    <= req_write;
            f3_q    <= req_funct3;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            if (fault_in) begin
              resp_misaligned <= 1'b1;
            end else if (req_write && req_funct3 == 3'b011) begin
              mem_waddress <= aligned_in;
              mem_datain   <= req_wdata;
            end else begin
              mem_raddress <= aligned_in;
              cnt          <= 3'(MEM_LATENCY);
            end
          end
        end
        RD_WAIT: begin
          cnt <= cnt - 3'd1;
          if (cnt == 3'd1) begin
            if (wr_q) begin
              mem_waddress <= aligned_q;
              mem_datain   <= merge(mem_dataout, wdata_q, addr_q[2:0], f3_q);
            end else begin
              resp_rdata      <= extract(mem_dataout, addr_q[2:0], f3_q);
              resp_misaligned <= 1'b0;
            end
          end
        end
        WRITE:   resp_misaligned <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: MEM_LATENCY=1 instance driven from a vector table, MEM_LATENCY=3 instance for busy-drop.
module tb_load_store_unit;

  logic        CLK = 1'b0;
  logic        rst_a, rst_b;
  logic        req_valid_a, req_valid_b;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [63:0] req_addr, req_wdata;

  logic        rdy_a, rv_a, mis_a, wr_a;
  logic [63:0] rdata_a, raddr_a, waddr_a, din_a, dout_a;
  logic        rdy_b, rv_b, mis_b, wr_b;
  logic [63:0] rdata_b, raddr_b, waddr_b, din_b, dout_b;

  logic [63:0] mem_a [0:31];
  logic [63:0] mem_b [0:31];
  logic        init_done;
  int          wr_cnt_a, wr_cnt_b;
  int          errors = 0;
  int          checks = 0;
  logic        sel;

  always #5 CLK = ~CLK;

  load_store_unit #(.MEM_LATENCY(1), .ADDR_W(64)) dut_a (
    .CLK(CLK), .RST(rst_a), .req_valid(req_valid_a), .req_ready(rdy_a),
    .req_write(req_write), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(rv_a), .resp_rdata(rdata_a), .resp_misaligned(mis_a),
    .mem_raddress(raddr_a), .mem_waddress(waddr_a), .mem_datain(din_a), .mem_wr(wr_a),
    .mem_dataout(dout_a));

  load_store_unit #(.MEM_LATENCY(3), .ADDR_W(64)) dut_b (
    .CLK(CLK), .RST(rst_b), .req_valid(req_valid_b), .req_ready(rdy_b),
    .req_write(req_write), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(rv_b), .resp_rdata(rdata_b), .resp_misaligned(mis_b),
    .mem_raddress(raddr_b), .mem_waddress(waddr_b), .mem_datain(din_b), .mem_wr(wr_b),
    .mem_dataout(dout_b));

  assign dout_a = mem_a[raddr_a[7:3]];
  assign dout_b = mem_b[raddr_b[7:3]];

  always @(posedge CLK) begin
    if (!init_done) begin
      for (int i = 0; i < 32; i++) begin
        mem_a[i] <= 64'd0;
        mem_b[i] <= 64'd0;
      end
      mem_a[0] <= 64'h8877665544332211;
      mem_b[0] <= 64'h8877665544332211;
      wr_cnt_a <= 0;
      wr_cnt_b <= 0;
    end else begin
      if (wr_a) mem_a[waddr_a[7:3]] <= din_a;
      if (wr_b) mem_b[waddr_b[7:3]] <= din_b;
      wr_cnt_a <= wr_cnt_a + (wr_a ? 1 : 0);
      wr_cnt_b <= wr_cnt_b + (wr_b ? 1 : 0);
    end
  end

  logic        rdy, rv, mis, mwr;
  logic [63:0] rdata, raddr, waddr, din;
  assign rdy   = sel ? rdy_b   : rdy_a;
  assign rv    = sel ? rv_b    : rv_a;
  assign mis   = sel ? mis_b   : mis_a;
  assign mwr   = sel ? wr_b    : wr_a;
  assign rdata = sel ? rdata_b : rdata_a;
  assign raddr = sel ? raddr_b : raddr_a;
  assign waddr = sel ? waddr_b : waddr_a;
  assign din   = sel ? din_b   : din_a;

  typedef struct {
    logic        wr;
    logic [2:0]  f3;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] exp_rdata;
    logic        exp_mis;
    int          exp_lat;
    int          exp_wr;
    logic [63:0] exp_wdat;
  } vec_t;

  vec_t vecs [19];

  function automatic vec_t mk(input logic wr, input logic [2:0] f3, input logic [63:0] addr,
                              input logic [63:0] wdata, input logic [63:0] rdata, input logic mis,
                              input int lat, input int wrc, input logic [63:0] wdat);
    vec_t v;
    v.wr = wr; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.exp_rdata = rdata;
    v.exp_mis = mis; v.exp_lat = lat; v.exp_wr = wrc; v.exp_wdat = wdat;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issues one request and follows it to its response; pulse_at > 0 injects a busy-time request.
  task automatic run_req(input logic s, input vec_t v, input string name, input int pulse_at);
    int          lat = 0;
    int          wr_at = 0;
    logic [63:0] wdat = '0;
    logic [63:0] wad = '0;
    sel = s;
    req_write = v.wr; req_funct3 = v.f3; req_addr = v.addr; req_wdata = v.wdata;
    if (s) req_valid_b = 1'b1; else req_valid_a = 1'b1;
    #1;
    check({name, " req_ready"}, 64'(rdy), 64'd1);
    @(posedge CLK); #1;
    req_valid_a = 1'b0; req_valid_b = 1'b0;
    for (int c = 1; c <= 20 && lat == 0; c++) begin
      if (c == 1 && v.exp_wr != 1 && !v.exp_mis)
        check({name, " raddr"}, raddr, {v.addr[63:3], 3'b000});
      if (c == pulse_at) begin
        check({name, " busy ready"}, 64'(rdy), 64'd0);
        req_write = 1'b1; req_funct3 = 3'b000; req_addr = 64'h100; req_wdata = 64'hFF;
        if (s) req_valid_b = 1'b1; else req_valid_a = 1'b1;
      end
      if (mwr) begin
        wr_at = (wr_at == 0) ? c : -1;
        wdat  = din;
        wad   = waddr;
      end
      if (rv) lat = c;
      else begin
        @(posedge CLK); #1;
        req_valid_a = 1'b0; req_valid_b = 1'b0;
      end
    end
    check({name, " latency"}, 64'(lat), 64'(v.exp_lat));
    check({name, " misaligned"}, 64'(mis), 64'(v.exp_mis));
    check({name, " rdata"}, rdata, v.exp_rdata);
    check({name, " wr cycle"}, 64'(wr_at), 64'(v.exp_wr));
    if (v.exp_wr != 0) begin
      check({name, " wdata"}, wdat, v.exp_wdat);
      check({name, " waddr"}, wad, {v.addr[63:3], 3'b000});
    end
    @(posedge CLK); #1;
    check({name, " resp one cycle"}, 64'(rv), 64'd0);
  endtask

  initial begin
    vec_t vb;
    int   wc;
    vecs[0]  = mk(0, 3'b000, 64'h103, 0, 64'h0000000000000044, 0, 2, 0, 0);
    vecs[1]  = mk(0, 3'b000, 64'h107, 0, 64'hFFFFFFFFFFFFFF88, 0, 2, 0, 0);
    vecs[2]  = mk(0, 3'b100, 64'h107, 0, 64'h0000000000000088, 0, 2, 0, 0);
    vecs[3]  = mk(0, 3'b101, 64'h106, 0, 64'h0000000000008877, 0, 2, 0, 0);
    vecs[4]  = mk(0, 3'b010, 64'h104, 0, 64'hFFFFFFFF88776655, 0, 2, 0, 0);
    vecs[5]  = mk(0, 3'b110, 64'h104, 0, 64'h0000000088776655, 0, 2, 0, 0);
    vecs[6]  = mk(0, 3'b011, 64'h100, 0, 64'h8877665544332211, 0, 2, 0, 0);
    vecs[7]  = mk(1, 3'b000, 64'h102, 64'hAB, 64'h8877665544332211, 0, 3, 2, 64'h8877665544AB2211);
    vecs[8]  = mk(0, 3'b011, 64'h100, 0, 64'h8877665544AB2211, 0, 2, 0, 0);
    vecs[9]  = mk(1, 3'b011, 64'h108, 64'h0123456789ABCDEF, 64'h8877665544AB2211, 0, 2, 1, 64'h0123456789ABCDEF);
    vecs[10] = mk(1, 3'b010, 64'h102, 64'h55, 64'h8877665544AB2211, 1, 1, 0, 0);
    vecs[11] = mk(0, 3'b111, 64'h100, 0, 64'h8877665544AB2211, 1, 1, 0, 0);
    vecs[12] = mk(0, 3'b011, 64'h108, 0, 64'h0123456789ABCDEF, 0, 2, 0, 0);
    vecs[13] = mk(0, 3'b001, 64'h101, 0, 64'h0123456789ABCDEF, 1, 1, 0, 0);
    vecs[14] = mk(1, 3'b001, 64'h10E, 64'hBEEF, 64'h0123456789ABCDEF, 0, 3, 2, 64'hBEEF456789ABCDEF);
    vecs[15] = mk(0, 3'b010, 64'h10C, 0, 64'hFFFFFFFFBEEF4567, 0, 2, 0, 0);
    vecs[16] = mk(1, 3'b100, 64'h108, 64'h77, 64'hFFFFFFFFBEEF4567, 1, 1, 0, 0);
    vecs[17] = mk(0, 3'b101, 64'h10E, 0, 64'h000000000000BEEF, 0, 2, 0, 0);
    vecs[18] = mk(0, 3'b011, 64'h104, 0, 64'h000000000000BEEF, 1, 1, 0, 0);

    rst_a = 1'b0; rst_b = 1'b0; init_done = 1'b0; sel = 1'b0;
    req_valid_a = 1'b0; req_valid_b = 1'b0;
    req_write = 1'b0; req_funct3 = '0; req_addr = '0; req_wdata = '0;
    repeat (3) @(posedge CLK);
    #1;
    init_done = 1'b1;

    check("reset resp_valid", 64'(rv_a), 64'd0);
    check("reset rdata", rdata_a, 64'd0);
    check("reset misaligned", 64'(mis_a), 64'd0);
    check("reset raddr", raddr_a, 64'd0);
    check("reset waddr", waddr_a, 64'd0);
    check("reset datain", din_a, 64'd0);
    check("reset mem_wr", 64'(wr_a), 64'd0);
    check("reset ready", 64'(rdy_a), 64'd1);

    rst_a = 1'b1; rst_b = 1'b1;
    @(posedge CLK); #1;

    for (int i = 0; i < 19; i++) run_req(1'b0, vecs[i], $sformatf("v%0d", i), 0);

    vb = mk(0, 3'b001, 64'h100, 0, 64'h0000000000002211, 0, 4, 0, 0);
    run_req(1'b1, vb, "lat3 lh", 2);
    check("lat3 no write", 64'(wr_cnt_b), 64'd0);
    check("lat3 mem kept", mem_b[0], 64'h8877665544332211);
    check("lat3 idle after", 64'(rdy_b), 64'd1);

    sel = 1'b0;
    req_write = 1'b1; req_funct3 = 3'b001; req_addr = 64'h104; req_wdata = 64'h1234;
    req_valid_a = 1'b1;
    @(posedge CLK); #1;
    req_valid_a = 1'b0;
    wc = wr_cnt_a;
    check("rst busy ready", 64'(rdy_a), 64'd0);
    rst_a = 1'b0;
    #1;
    check("rst mem_wr", 64'(wr_a), 64'd0);
    check("rst ready", 64'(rdy_a), 64'd1);
    check("rst rdata", rdata_a, 64'd0);
    check("rst raddr", raddr_a, 64'd0);
    check("rst waddr", waddr_a, 64'd0);
    check("rst datain", din_a, 64'd0);
    check("rst resp_valid", 64'(rv_a), 64'd0);
    repeat (2) @(posedge CLK);
    #1;
    rst_a = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    check("rst no write", 64'(wr_cnt_a - wc), 64'd0);
    check("rst mem kept", mem_a[0], 64'h8877665544AB2211);
    check("rst still idle", 64'(rdy_a), 64'd1);
    vb = mk(0, 3'b000, 64'h100, 0, 64'h0000000000000011, 0, 2, 0, 0);
    run_req(1'b0, vb, "post rst lb", 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
